pll_lock_supervisor: RTL

Sits directly downstream of the iCE40 `SB_PLL40_CORE` instance and consumes its asynchronous `LOCK` output. Lock must stay high for a programmable number of reference-clock cycles before the supervisor releases a synchronous system reset to logic fed by `PLLOUTCORE`. It also counts lock-loss events and reports status suitable for routing to a pmod header. It runs on the board reference clock, which keeps running while the PLL is unlocked.

---
 rtl/pll_lock_supervisor.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/pll_lock_supervisor.sv
// Qualifies the asynchronous PLL LOCK and sequences a synchronous system reset for PLLOUTCORE logic.
// Define PLL_LOCK_SUPERVISOR_LOSS_COUNT_EN to build the lock-loss counter, sticky flag and loss_clear.
module pll_lock_supervisor #(
  parameter int unsigned LOCK_STABLE = 1024,
  parameter int unsigned RST_HOLD    = 16,
  parameter int unsigned CNT_W       = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pll_lock,
  input  logic       loss_clear,
  output logic       sys_rst,
  output logic       ready,
  output logic [1:0] state,
  output logic [7:0] loss_count,
  output logic       lost_sticky
);

  typedef enum logic [1:0] {
    UNLOCKED  = 2'd0,
    STABILIZE = 2'd1,
    HOLD      = 2'd2,
    RUN       = 2'd3
  } state_e;

  localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(LOCK_STABLE - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(RST_HOLD - 1);

  logic             s1_q, s1_d;
  logic             s2_q, s2_d;
  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sys_rst_q, sys_rst_d;
  logic             ready_q, ready_d;
  logic             loss_evt;

  // Synchroniser stage boundary: only s2_q (lock_s) is seen by the FSM
  always_comb begin
    s1_d = pll_lock;
    s2_d = s1_q;
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    loss_evt = 1'b0;
    case (state_q)
      UNLOCKED: begin
        cnt_d = '0;
        if (s2_q) state_d = STABILIZE;
      end
      STABILIZE: begin
        if (!s2_q) begin
          state_d = UNLOCKED;
          cnt_d   = '0;
        end else if (cnt_q == STABLE_LAST) begin
          state_d = HOLD;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      HOLD: begin
        if (!s2_q) begin
          state_d = UNLOCKED;
          cnt_d   = '0;
        end else if (cnt_q == HOLD_LAST) begin
          state_d = RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RUN: begin
        cnt_d = '0;
        if (!s2_q) begin
          state_d  = UNLOCKED;
          loss_evt = 1'b1;
        end
      end
      default: begin
        state_d = UNLOCKED;
        cnt_d   = '0;
      end
    endcase
    // Outputs are registered from the next state so they track state_q exactly
    sys_rst_d = (state_d != RUN);
    ready_d   = (state_d == RUN);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q      <= 1'b0;
      s2_q      <= 1'b0;
      state_q   <= UNLOCKED;
      cnt_q     <= '0;
      sys_rst_q <= 1'b1;
      ready_q   <= 1'b0;
    end else begin
      s1_q      <= s1_d;
      s2_q      <= s2_d;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      sys_rst_q <= sys_rst_d;
      ready_q   <= ready_d;
    end
  end

  assign sys_rst = sys_rst_q;
  assign ready   = ready_q;
  assign state   = state_q;

`ifdef PLL_LOCK_SUPERVISOR_LOSS_COUNT_EN
  logic [7:0] loss_count_q, loss_count_d;
  logic       lost_sticky_q, lost_sticky_d;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // A loss on the same edge as loss_clear wins and restarts the count at 1
  always_comb begin
    loss_count_d  = loss_count_q;
    lost_sticky_d = lost_sticky_q;
    if (loss_evt) begin
      loss_count_d  = loss_clear ? 8'd1 : sat_inc8(loss_count_q);
      lost_sticky_d = 1'b1;
    end else if (loss_clear) begin
      loss_count_d  = 8'd0;
      lost_sticky_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      loss_count_q  <= 8'd0;
      lost_sticky_q <= 1'b0;
    end else begin
      loss_count_q  <= loss_count_d;
      lost_sticky_q <= lost_sticky_d;
    end
  end

  assign loss_count  = loss_count_q;
  assign lost_sticky = lost_sticky_q;
`else
  logic [1:0] unused_loss;
  assign unused_loss = {loss_clear, loss_evt};
  assign loss_count  = 8'd0;
  assign lost_sticky = 1'b0;
`endif

endmodule
